serial_adder_ctrl: RTL and testbench

- Bit-serial N-bit adder. Sits directly downstream of the team's single-bit add cells and reuses one full-adder slice across all bit positions.
- Accepts two operands and a carry-in over a valid/ready handshake. Adds LSB-first at one bit per clock with a registered carry. Presents sum and carry-out over a second valid/ready handshake.
- Trades WIDTH cycles of latency for a one-slice datapath in area-constrained arithmetic paths.

---
 rtl/serial_add_pkg.sv | 12 +
 rtl/serial_adder_ctrl_fa_slice.sv | 20 ++
 rtl/serial_adder_ctrl.sv | 127 ++++++++++++
 tb/tb_serial_adder_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package serial_add_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/serial_adder_ctrl_fa_slice.sv
// Single-bit full adder: two half-adder stages with their carries ORed together.
module fa_slice (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    logic p1;
    logic g1;
    logic g2;

    assign p1  = a_i ^ b_i;
    assign g1  = a_i & b_i;
    assign s_o = p1 ^ c_i;
    assign g2  = p1 & c_i;
    assign c_o = g1 | g2;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder slice, LSB first, valid/ready on both sides.
// Define SERIAL_ADD_OVF_EN to add the registered two's-complement overflow output ovf.
module serial_adder_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_e           state_q,  state_d;
    logic [WIDTH-1:0] a_sr_q,   a_sr_d;
    logic [WIDTH-1:0] b_sr_q,   b_sr_d;
    logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
    logic             carry_q,  carry_d;
    logic [CW-1:0]    cnt_q,    cnt_d;

    logic fa_s;
    logic fa_c;

    fa_slice u_fa (
        .a_i (a_sr_q[0]),
        .b_i (b_sr_q[0]),
        .c_i (carry_q),
        .s_o (fa_s),
        .c_o (fa_c)
    );

`ifdef SERIAL_ADD_OVF_EN
    logic ovf_q, ovf_d;
`endif

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        sum_sr_d = sum_sr_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
`ifdef SERIAL_ADD_OVF_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                sum_sr_d = {fa_s, sum_sr_q[WIDTH-1:1]};
                carry_d  = fa_c;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d = DONE;
`ifdef SERIAL_ADD_OVF_EN
                    // carry_q is the carry into the MSB on this final edge
                    ovf_d   = carry_q ^ fa_c;
`endif
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            sum_sr_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            sum_sr_q <= sum_sr_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum       = sum_sr_q;
    assign cout      = carry_q;
`ifdef SERIAL_ADD_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: driver pushes a + b + cin results, monitor pops on handoff.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
`endif

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           acc;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   stall_cfg = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Reference: plain (W+1)-bit arithmetic; overflow from operand/result sign rule.
    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
        exp_t         e;
        logic [W:0]   full;
        full   = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, cv};
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (av[W-1] == bv[W-1]) && (e.sum[W-1] != av[W-1]);
        e.acc  = 0;
        e.a    = av;
        e.b    = bv;
        e.cin  = cv;
        return e;
    endfunction

    // Monitor: latency, stability under stall, handoff, scoreboard compare.
    logic         prev_valid = 1'b0;
    logic         after_handoff = 1'b0;
    logic [W-1:0] held_sum;
    logic         held_cout;
    int           age = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid    = 1'b0;
            after_handoff = 1'b0;
            out_ready     = 1'b0;
        end else begin
            if (after_handoff) begin
                check("handoff_out_valid", out_valid, 0);
                check("handoff_in_ready", in_ready, 1);
                after_handoff = 1'b0;
            end
            if (out_valid) begin
                if (!prev_valid) begin
                    age = 0;
                    if (sb.size() == 0) check("unexpected_result", 1, 0);
                    else check("latency", cyc - sb[0].acc, W);
                end else begin
                    age++;
                    check("stall_sum_stable", sum, held_sum);
                    check("stall_cout_stable", cout, held_cout);
                end
                held_sum  = sum;
                held_cout = cout;
                check("done_in_ready", in_ready, 0);
                check("done_busy", busy, 1);
                out_ready = (age >= stall_cfg) ? ($urandom_range(0, 2) != 0) : 1'b0;
                if (out_ready && sb.size() > 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sum", sum, e.sum);
                    check("cout", cout, e.cout);
`ifdef SERIAL_ADD_OVF_EN
                    check("ovf", ovf, e.ovf);
`endif
                    $display("result a=%h b=%h cin=%0d -> sum=%h cout=%0d", e.a, e.b, e.cin, sum, cout);
                    after_handoff = 1'b1;
                end
            end else begin
                out_ready = $urandom_range(0, 1) != 0;
            end
            prev_valid = out_valid;
        end
    end

    task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv, input int junk);
        exp_t e;
        int   t;
        @(negedge clk);
        a = av;
        b = bv;
        cin = cv;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            check("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        e = model(av, bv, cv);
        e.acc = cyc;
        sb.push_back(e);
        // Different operands held valid while busy must be ignored
        for (int j = 0; j < junk; j++) begin
            a = W'($urandom);
            b = W'($urandom);
            cin = 1'($urandom);
            check("shift_in_ready", in_ready, 0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb.size() > 0 || out_valid) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("drain_queue", sb.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_busy", busy, 0);
`ifdef SERIAL_ADD_OVF_EN
        check("rst_ovf", ovf, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        send(8'h3C, 8'h05, 1'b0, 0);
        send(8'hFF, 8'h00, 1'b1, 0);
        send(8'hFF, 8'hFF, 1'b1, 0);
        drain();

        stall_cfg = 5;
        send(8'h12, 8'h34, 1'b0, 0);
        drain();
        stall_cfg = 0;

        send(8'h10, 8'h20, 1'b1, W - 2);
        send(8'h07, 8'h09, 1'b0, 0);
        drain();

        // Abort mid-shift: the pushed expectation is discarded, nothing must emerge
        send(8'hAA, 8'h55, 1'b0, 0);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        void'(sb.pop_back());
        #1;
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_sum", sum, 0);
        check("abort_cout", cout, 0);
        check("abort_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < W + 4; k++) begin
            @(negedge clk);
            if (k == W + 3) check("abort_no_result", out_valid, 0);
        end
        send(8'h01, 8'h01, 1'b0, 0);
        drain();

`ifdef SERIAL_ADD_OVF_EN
        send(8'h7F, 8'h01, 1'b0, 0);
        send(8'h80, 8'hFF, 1'b0, 0);
        drain();
`endif

        for (int i = 0; i < 40; i++) begin
            stall_cfg = $urandom_range(0, 3);
            send(W'($urandom), W'($urandom), 1'($urandom), $urandom_range(0, W - 2));
        end
        drain();
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
